// File: rtl/video_timing_pattern_gen.sv
// Programmable FV/LV frame timing and test-pattern source (bars/solid/ramp).
// Optional feature macro: VTPG_RAMP_PATTERN_EN compiles the ramp pattern (sel 2).
`timescale 1ns/1ps
module video_timing_pattern_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_W      = 16,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic [DIM_W-1:0]      image_width_i,
    input  logic [DIM_W-1:0]      image_height_i,
    input  logic [DIM_W-1:0]      h_blank_i,
    input  logic [CNT_W-1:0]      frame_period_i,
    input  logic [1:0]            pattern_sel_i,
    input  logic [31:0]           solid_colour_i,
    output logic                  fv_o,
    output logic                  lv_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic [15:0]           frame_cnt_o,
    output logic                  cfg_err_o
);

    typedef enum logic [1:0] {IDLE, H_BLANK, ACTIVE, V_BLANK} state_t;

    state_t           state;
    state_t           next_state;
    logic [DIM_W-1:0] width;
    logic [DIM_W-1:0] height;
    logic [DIM_W-1:0] hblank;
    logic [CNT_W-1:0] period;
    logic [1:0]       pattern;
    logic [31:0]      solid;
    logic [DIM_W-1:0] pix_idx;
    logic [DIM_W-1:0] line_idx;
    logic [DIM_W-1:0] band_cnt;
    logic [2:0]       band;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W:0]   pcnt_p1;
    logic [CNT_W:0]   pcnt_p2;
    logic             overrun;
    logic             eof_q;
    logic             err_q;
    logic [15:0]      fcnt;
    logic [31:0]      word;

    logic cfg_ok;
    logic hb_done;
    logic act_done;
    logic last_line;
    logic band_done;
    logic ovr_now;
    logic vb_done;
    logic load;
    logic start;

    assign cfg_ok    = (image_width_i >= DIM_W'(8)) &&
                       (image_height_i != '0) && (h_blank_i != '0);
    assign hb_done   = pix_idx == hblank - DIM_W'(1);
    assign act_done  = pix_idx == width - DIM_W'(1);
    assign last_line = line_idx == height - DIM_W'(1);
    assign band_done = band_cnt == (width >> 3) - DIM_W'(1);
    assign pcnt_p1   = {1'b0, pcnt} + (CNT_W+1)'(1);
    assign pcnt_p2   = pcnt_p1 + (CNT_W+1)'(1);
    // V_BLANK would start at or past period-1: fall back to h_blank clocks
    assign ovr_now   = pcnt_p2 >= {1'b0, period};
    assign vb_done   = overrun ? hb_done : (pcnt_p1 == {1'b0, period});

    assign eof_o       = eof_q;
    assign frame_cnt_o = fcnt;
    assign cfg_err_o   = err_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next state, shadow load/frame start strobes and timing outputs
    always_comb begin
        next_state = state;
        load       = 1'b0;
        start      = 1'b0;
        fv_o       = 1'b0;
        lv_o       = 1'b0;
        sof_o      = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable_i) begin
                    load = 1'b1;
                    if (cfg_ok) begin
                        start      = 1'b1;
                        next_state = H_BLANK;
                    end
                end
            end
            H_BLANK: begin
                fv_o  = 1'b1;
                sof_o = (line_idx == '0) && (pix_idx == '0);
                if (hb_done) next_state = ACTIVE;
            end
            ACTIVE: begin
                fv_o = 1'b1;
                lv_o = 1'b1;
                if (act_done) next_state = last_line ? V_BLANK : H_BLANK;
            end
            V_BLANK: begin
                if (vb_done) begin
                    load = 1'b1;
                    if (enable_i && cfg_ok) begin
                        start      = 1'b1;
                        next_state = H_BLANK;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow config, pixel/line/band/period counters, error and frame count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            width    <= '0;
            height   <= '0;
            hblank   <= '0;
            period   <= '0;
            pattern  <= '0;
            solid    <= '0;
            pix_idx  <= '0;
            line_idx <= '0;
            band_cnt <= '0;
            band     <= '0;
            pcnt     <= '0;
            overrun  <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;
            fcnt     <= '0;
        end else begin
            eof_q <= 1'b0;
            pcnt  <= start ? '0 : pcnt + CNT_W'(1);
            if (load) begin
                width   <= image_width_i;
                height  <= image_height_i;
                hblank  <= h_blank_i;
                period  <= frame_period_i;
                pattern <= pattern_sel_i;
                solid   <= solid_colour_i;
                err_q   <= !cfg_ok;
            end
            unique case (state)
                H_BLANK: begin
                    pix_idx  <= hb_done ? '0 : pix_idx + DIM_W'(1);
                    band_cnt <= '0;
                    band     <= '0;
                end
                ACTIVE: begin
                    pix_idx <= act_done ? '0 : pix_idx + DIM_W'(1);
                    if (band_done) begin
                        band_cnt <= '0;
                        if (band != 3'd7) band <= band + 3'd1;
                    end else begin
                        band_cnt <= band_cnt + DIM_W'(1);
                    end
                    if (act_done) begin
                        if (last_line) begin
                            eof_q   <= 1'b1;
                            fcnt    <= fcnt + 16'd1;
                            overrun <= ovr_now;
                            if (ovr_now) err_q <= 1'b1;
                        end else begin
                            line_idx <= line_idx + DIM_W'(1);
                        end
                    end
                end
                V_BLANK: pix_idx <= vb_done ? '0 : pix_idx + DIM_W'(1);
                default: ;
            endcase
            if (start) begin
                pix_idx  <= '0;
                line_idx <= '0;
            end
        end
    end

    // Pattern word for the current pixel, replicated across the bus
    always_comb begin
        unique case (band)
            3'd0:    word = 32'hFF80FF80;
            3'd1:    word = 32'hFF94FF00;
            3'd2:    word = 32'hC81AC8BF;
            3'd3:    word = 32'hCA4ACA55;
            3'd4:    word = 32'h96F3969F;
            3'd5:    word = 32'h4CFF4C54;
            3'd6:    word = 32'h409E40D3;
            default: word = 32'h00800080;
        endcase
        if (pattern == 2'd1) word = solid;
`ifdef VTPG_RAMP_PATTERN_EN
        else if (pattern == 2'd2) word = {16'(line_idx), 16'(pix_idx)};
`endif
        data_o = lv_o ? {(DATA_WIDTH/32){word}} : '0;
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Bench for video_timing_pattern_gen: frame-offset reference model plus
// directed timing, pattern, reset and configuration-error scenarios.
`timescale 1ns/1ps
module tb_video_timing_pattern_gen;

    localparam int DW = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable_i = 1'b0;
    logic [15:0] image_width_i = 16'd16;
    logic [15:0] image_height_i = 16'd4;
    logic [15:0] h_blank_i = 16'd4;
    logic [31:0] frame_period_i = 32'd200;
    logic [1:0]  pattern_sel_i = 2'd0;
    logic [31:0] solid_colour_i = 32'h1234ABCD;
    logic          fv_o, lv_o, sof_o, eof_o, cfg_err_o;
    logic [DW-1:0] data_o;
    logic [15:0]   frame_cnt_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] bars [8] = '{32'hFF80FF80, 32'hFF94FF00, 32'hC81AC8BF,
                              32'hCA4ACA55, 32'h96F3969F, 32'h4CFF4C54,
                              32'h409E40D3, 32'h00800080};
    logic [63:0] line0 [16];

    video_timing_pattern_gen #(.DATA_WIDTH(DW), .DIM_W(16), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i),
        .image_width_i(image_width_i), .image_height_i(image_height_i),
        .h_blank_i(h_blank_i), .frame_period_i(frame_period_i),
        .pattern_sel_i(pattern_sel_i), .solid_colour_i(solid_colour_i),
        .fv_o(fv_o), .lv_o(lv_o), .data_o(data_o), .sof_o(sof_o),
        .eof_o(eof_o), .frame_cnt_o(frame_cnt_o), .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame described by its latched config and offset
    bit          m_run = 0;
    int          m_t = 0;
    int          mw = 0, mh = 0, mhb = 0;
    longint      mp = 0;
    logic [1:0]  mpat = 0;
    logic [31:0] msolid = 0;
    bit          m_err = 0;
    logic [15:0] m_fcnt = 0;

    function automatic int fvh_f();
        return mh * (mhb + mw);
    endfunction

    function automatic int vbl_f();
        int f = fvh_f();
        return (longint'(f) >= mp - 1) ? mhb : int'(mp - longint'(f));
    endfunction

    function automatic bit in_valid();
        return image_width_i >= 16'd8 && image_height_i != 0 && h_blank_i != 0;
    endfunction

    function automatic logic [31:0] pix_word(input int ln, input int px);
        int b, bd;
        if (mpat == 2'd1) return msolid;
`ifdef VTPG_RAMP_PATTERN_EN
        if (mpat == 2'd2) return {ln[15:0], px[15:0]};
`endif
        b  = mw / 8;
        bd = px / b;
        if (bd > 7) bd = 7;
        return bars[bd];
    endfunction

    task automatic latch_cfg();
        mw     = int'(image_width_i);
        mh     = int'(image_height_i);
        mhb    = int'(h_blank_i);
        mp     = longint'(frame_period_i);
        mpat   = pattern_sel_i;
        msolid = solid_colour_i;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_t = 0; m_err = 0; m_fcnt = 0;
        end else if (!m_run) begin
            if (enable_i) begin
                latch_cfg();
                m_err = !in_valid();
                if (!m_err) begin m_run = 1; m_t = 0; end
            end
        end else if (m_t == fvh_f() + vbl_f() - 1) begin
            latch_cfg();
            m_err = !in_valid();
            if (enable_i && !m_err) m_t = 0;
            else m_run = 0;
        end else begin
            m_t++;
            if (m_t == fvh_f()) begin
                m_fcnt++;
                if (longint'(fvh_f()) >= mp - 1) m_err = 1;
            end
        end
    end

    // Compare every cycle against the model
    always @(negedge clk) begin
        logic e_fv, e_lv, e_sof, e_eof;
        logic [63:0] e_data;
        int f, ln, x;
        e_fv = 0; e_lv = 0; e_sof = 0; e_eof = 0; e_data = '0;
        if (m_run) begin
            f = fvh_f();
            if (m_t < f) begin
                e_fv  = 1;
                e_sof = (m_t == 0);
                ln = m_t / (mhb + mw);
                x  = m_t % (mhb + mw);
                if (x >= mhb) begin
                    e_lv   = 1;
                    e_data = {2{pix_word(ln, x - mhb)}};
                end
            end else begin
                e_eof = (m_t == f);
            end
        end
        check("m_fv", fv_o, e_fv);
        check("m_lv", lv_o, e_lv);
        check("m_data", data_o, e_data);
        check("m_sof", sof_o, e_sof);
        check("m_eof", eof_o, e_eof);
        check("m_fcnt", frame_cnt_o, m_fcnt);
        check("m_err", cfg_err_o, m_err);
    end

    // Starts on a negedge with sof_o high; ends on the next sof or max_lo low clocks
    task automatic measure(input int drop_at, input int max_lo, output int hi,
                           output int lo, output int lvc, output bit errlo);
        int n = 0;
        hi = 0; lo = 0; lvc = 0; errlo = 0;
        while (fv_o === 1'b1 && n < 5000) begin
            if (hi == drop_at) enable_i = 1'b0;
            if (lv_o && lvc < 16) line0[lvc] = data_o;
            if (lv_o) lvc++;
            hi++; n++;
            @(negedge clk);
        end
        if (n >= 5000) begin
            tests++; fails++;
            $display("FAIL measure_timeout: fv_o high for %0d cycles", n);
        end
        while (sof_o !== 1'b1 && lo < max_lo) begin
            if (cfg_err_o) errlo = 1;
            lo++;
            @(negedge clk);
        end
    endtask

    task automatic wait_sof(input int bound);
        int n = 0;
        @(negedge clk);
        while (sof_o !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) begin
            tests++; fails++;
            $display("FAIL wait_sof: no sof within %0d cycles", bound);
        end
    endtask

    initial begin
        int hi, lo, lvc;
        bit errlo;
        logic [31:0] ramp_exp;
        repeat (3) @(negedge clk);
        check("rst_fv", fv_o, 0);
        check("rst_lv", lv_o, 0);
        check("rst_data", data_o, 0);
        check("rst_sof", sof_o, 0);
        check("rst_eof", eof_o, 0);
        check("rst_fcnt", frame_cnt_o, 0);
        check("rst_err", cfg_err_o, 0);
        reset_n = 1'b1;
        @(negedge clk);
        enable_i = 1'b1;
        @(negedge clk);
        check("sof_after_en", sof_o, 1);
        check("fv_after_en", fv_o, 1);

        // Frame 1: W16 H4 HB4 P200, colour bars
        measure(-1, 300, hi, lo, lvc, errlo);
        check("f1_fv_hi", hi, 80);
        check("f1_fv_lo", lo, 120);
        check("f1_lv_cnt", lvc, 64);
        check("f1_err", errlo, 0);
        check("f1_px0", line0[0], 64'hFF80FF80_FF80FF80);
        check("f1_px1", line0[1], 64'hFF80FF80_FF80FF80);
        check("f1_px2", line0[2], 64'hFF94FF00_FF94FF00);
        check("f1_px4", line0[4], 64'hC81AC8BF_C81AC8BF);
        check("f1_px15", line0[15], 64'h00800080_00800080);
        check("f1_fcnt", frame_cnt_o, 1);

        // Period overrun: P=50 set during frame 2, takes effect in frame 3
        frame_period_i = 32'd50;
        measure(-1, 300, hi, lo, lvc, errlo);
        check("f2_fv_lo", lo, 120);
        measure(-1, 300, hi, lo, lvc, errlo);
        check("f3_fv_hi", hi, 80);
        check("f3_fv_lo", lo, 4);
        check("f3_err", errlo, 1);
        frame_period_i = 32'd200;
        measure(-1, 300, hi, lo, lvc, errlo);
        check("f4_fv_lo", lo, 4);
        check("f5_err_start", cfg_err_o, 0);
        measure(-1, 300, hi, lo, lvc, errlo);
        check("f5_fv_lo", lo, 120);
        check("f5_err", errlo, 0);

        // Width change mid-frame only applies to the following frame
        image_width_i = 16'd32;
        measure(-1, 300, hi, lo, lvc, errlo);
        check("f6_fv_hi", hi, 80);
        check("f6_lv_cnt", lvc, 64);
        image_width_i = 16'd16;
        check("f7_fcnt", frame_cnt_o, 6);
        measure(-1, 300, hi, lo, lvc, errlo);
        check("f7_fv_hi", hi, 144);
        check("f7_lv_cnt", lvc, 128);
        check("f7_fv_lo", lo, 56);

        // Enable dropped at line 2: frame completes, then stays idle
        measure(44, 300, hi, lo, lvc, errlo);
        check("f8_fv_hi", hi, 80);
        check("f8_no_sof", lo, 300);
        check("f8_idle_fv", fv_o, 0);

        // Asynchronous reset in the middle of an active line
        enable_i = 1'b1;
        @(negedge clk);
        check("sof_restart", sof_o, 1);
        repeat (10) @(negedge clk);
        check("pre_rst_lv", lv_o, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_fv", fv_o, 0);
        check("arst_lv", lv_o, 0);
        check("arst_data", data_o, 0);
        check("arst_fcnt", frame_cnt_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("sof_after_rst", sof_o, 1);

        // Ramp (or bars without the ramp build) at line 3 pixel 5
        pattern_sel_i = 2'd2;
        wait_sof(400);
        pattern_sel_i = 2'd1;
        repeat (69) @(negedge clk);
`ifdef VTPG_RAMP_PATTERN_EN
        ramp_exp = 32'h00030005;
`else
        ramp_exp = 32'hC81AC8BF;
`endif
        check("ramp_lv", lv_o, 1);
        check("ramp_lo", data_o[31:0], ramp_exp);
        check("ramp_hi", data_o[63:32], ramp_exp);

        // Solid colour frame
        wait_sof(400);
        repeat (10) @(negedge clk);
        check("solid", data_o, {2{32'h1234ABCD}});

        // Invalid width: error flagged, block stays idle
        enable_i = 1'b0;
        repeat (250) @(negedge clk);
        image_width_i = 16'd4;
        enable_i = 1'b1;
        @(negedge clk);
        check("bad_cfg_err", cfg_err_o, 1);
        @(negedge clk);
        check("bad_cfg_fv", fv_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
